freq_display_scan: RTL and testbench
====================================

Name: freq_display_scan

Overview:
- Reader side of the frequency meter's latched result bus: consumes the eight latched BCD digits d0..d7 and drives an 8-digit multiplexed common-anode 7-segment display.
- Captures the digits into a shadow register once per scan frame, so each frame is coherent.
- Time-multiplexes one digit at a time, with leading-zero blanking and invalid-code indication.

Parameters:
- SCAN_DIV, 50000: clk cycles each digit stays selected; legal range >= 2.
- BLANK_LEAD, 1: 1 = blank leading zeros, 0 = show all eight digits.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- d0..d7  in  4 each  latched BCD digits; d0 = least significant, d7 = most significant
- disp_en  in  1  1 = display on, 0 = all digits dark
- an  out  8  digit select, active-low; an[k] selects digit k
- seg  out  8  segments, active-low; seg[7] = dp, seg[6:0] = g,f,e,d,c,b,a

Behaviour:
- Reset (rst_n low, asynchronous):
  - an = 8'hFF, seg = 8'hFF.
  - Prescaler = 0, digit index idx = 0, shadow digits = 0.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps to 0.
  - tick is asserted when prescaler == SCAN_DIV-1.
- Digit index:
  - On tick, idx increments, wrapping 7 -> 0.
  - Advances regardless of disp_en.
- Shadow load:
  - On the tick where idx goes 7 -> 0, shadow[k] <= dk for all k, in the same clock edge.
  - Input changes at any other time are not displayed until the next frame boundary.
- Blanking:
  - Digit k (k >= 1) is blank when BLANK_LEAD = 1 and shadow[k..7] are all 0.
  - Digit 0 is never blanked.
  - Blanking is evaluated on the shadow register only.
- Segment code (registered, active-low, dp always off):
  - 0 -> C0, 1 -> F9, 2 -> A4, 3 -> B0, 4 -> 99
  - 5 -> 92, 6 -> 82, 7 -> F8, 8 -> 80, 9 -> 90
  - Codes 10..15 -> BF (dash, segment g only)
  - Blank -> FF
- Output registers:
  - an and seg are registered from the current idx and shadow, giving 1 cycle latency.
  - When disp_en = 1: an = ~(8'b1 << idx).
  - Because latency is one cycle for both idx and shadow, the first cycle of digit 0 already shows the new frame.
- disp_en:
  - Sampled each cycle; disp_en = 0 forces an = FF and seg = FF on the next edge.
  - Prescaler, idx and shadow keep running while disp_en = 0.
  - When disp_en returns to 1, the display resumes at the current idx with no restart.
- Only one an bit is ever low. an and seg change together on the same edge, so no cross-digit ghost cycle appears.
- Reset asserted mid-scan:
  - Outputs go immediately to FF.
  - After release, scanning restarts at idx = 0 with shadow = 0.
  - Display shows "0" on digit 0 until the first frame boundary loads real data.
- Frame period = 8 × SCAN_DIV cycles; each digit is selected for exactly SCAN_DIV consecutive cycles.

Test Plan:
- Reset: assert rst_n = 0 mid-cycle -> an = FF and seg = FF immediately. Release with SCAN_DIV = 4, disp_en = 1 -> an = FE, seg = C0 for 4 cycles, then an = FD, seg = FF (blank).
- Scan order and wrap (SCAN_DIV = 4, BLANK_LEAD = 0, d7..d0 = 8'h76543210 BCD), after the first frame load:
  - an walks FE, FD, FB, F7, EF, DF, BF, 7F, each held 4 cycles, then back to FE.
  - seg is C0, F9, A4, B0, 99, 92, 82, F8 in that order.
- Leading-zero blanking (BLANK_LEAD = 1, digits = 00000120):
  - Digit 0 -> C0, digit 1 -> A4, digit 2 -> F9.
  - Digits 3..7 -> seg FF while their an bit is low.
  - Variant: digits = 00000000 -> only digit 0 shows C0.
- Frame coherence: change d0 from 3 to 8 while idx = 4 -> digit 0 still shows B0 for the remainder of that frame; 80 appears only after the 7 -> 0 wrap.
- Invalid code: d2 = 4'hB, d7 = 1 -> digit 2 shows BF; digits 3..6 show C0 (not blanked, since d7 is nonzero).
- disp_en toggle: drop disp_en at idx = 3 for 10 cycles -> an = FF and seg = FF starting one cycle later. On restore, the displayed digit matches the idx that continued advancing, and the frame period is unchanged.

Source files
------------

// File: rtl/freq_display_scan_if.sv
// Bus between the latched frequency-meter result and the display scanner.
// Carries the eight BCD digits and the display enable toward the scanner,
// and the multiplexed anode/segment drive back out toward the pins.
interface freq_display_scan_if;
    logic [3:0] d0;
    logic [3:0] d1;
    logic [3:0] d2;
    logic [3:0] d3;
    logic [3:0] d4;
    logic [3:0] d5;
    logic [3:0] d6;
    logic [3:0] d7;
    logic       disp_en;
    logic [7:0] an;
    logic [7:0] seg;

    modport master (
        output d0, d1, d2, d3, d4, d5, d6, d7, disp_en,
        input  an, seg
    );

    modport slave (
        input  d0, d1, d2, d3, d4, d5, d6, d7, disp_en,
        output an, seg
    );
endinterface

// File: rtl/freq_display_scan.sv
// Eight-digit multiplexed common-anode 7-segment driver for the frequency
// meter. Digits are captured into a shadow register once per scan frame so a
// frame never mixes old and new readings; leading zeros may be blanked and
// non-BCD codes are shown as a dash.
module freq_display_scan #(
    parameter int SCAN_DIV   = 50000,
    parameter int BLANK_LEAD = 1
) (
    input logic                 clk,
    input logic                 rst_n,
    freq_display_scan_if.slave  bus
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    logic [PW-1:0]       presc;
    logic                tick;
    logic [2:0]          idx;
    logic [7:0][3:0]     shadow;
    logic [7:0][3:0]     digits_in;
    logic [7:0]          blank;
    logic                higher_nz;

    assign digits_in = {bus.d7, bus.d6, bus.d5, bus.d4,
                        bus.d3, bus.d2, bus.d1, bus.d0};

    assign tick = (presc == PW'(SCAN_DIV - 1));

    // Active-low segment pattern for one digit; codes above 9 show a dash.
    function automatic logic [7:0] seg_code(input logic [3:0] v);
        logic [7:0] s;
        case (v)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hBF;
        endcase
        return s;
    endfunction

    // Prescaler, digit index and frame-boundary shadow capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc  <= '0;
            idx    <= 3'd0;
            shadow <= '0;
        end else if (tick) begin
            presc <= '0;
            idx   <= idx + 3'd1;
            if (idx == 3'd7) begin
                shadow <= digits_in;
            end
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // A digit is blank when it and every more significant digit are zero.
    always_comb begin
        blank     = '0;
        higher_nz = 1'b0;
        for (int k = 7; k >= 1; k--) begin
            higher_nz = higher_nz | (shadow[k] != 4'd0);
            blank[k]  = (BLANK_LEAD != 0) && !higher_nz;
        end
    end

    // Anode and segment registers move together so no ghost digit appears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.an  <= 8'hFF;
            bus.seg <= 8'hFF;
        end else if (!bus.disp_en) begin
            bus.an  <= 8'hFF;
            bus.seg <= 8'hFF;
        end else begin
            bus.an  <= ~(8'b1 << idx);
            bus.seg <= blank[idx] ? 8'hFF : seg_code(shadow[idx]);
        end
    end

endmodule

// File: tb/tb_freq_display_scan.sv
// Bench for freq_display_scan: two instances (blanking off and on) share the
// clock, reset and stimulus; a timeline model predicts the display from the
// number of edges since reset and the digits present at each frame boundary.
`timescale 1ns/1ps
module tb_freq_display_scan;

    localparam int SD = 4;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    freq_display_scan_if if_a ();
    freq_display_scan_if if_b ();

    freq_display_scan #(.SCAN_DIV(SD), .BLANK_LEAD(0)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a.slave)
    );

    freq_display_scan #(.SCAN_DIV(SD), .BLANK_LEAD(1)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b.slave)
    );

    // Free-running clock, 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [3:0] frame [8];
    int         edges;
    int         disp_digit;
    logic [7:0] exp_an;
    logic [7:0] exp_seg_a;
    logic [7:0] exp_seg_b;

    function automatic logic [7:0] ref_pattern(input logic [3:0] v);
        logic [7:0] t [10];
        t = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        if (v > 4'd9) return 8'hBF;
        return t[v];
    endfunction

    function automatic logic [7:0] ref_seg(input int dig, input bit blank_lead);
        bit all_zero;
        all_zero = 1'b1;
        for (int j = dig; j < 8; j++) begin
            if (frame[j] != 4'd0) all_zero = 1'b0;
        end
        if (blank_lead && dig > 0 && all_zero) return 8'hFF;
        return ref_pattern(frame[dig]);
    endfunction

    // Timeline model: edge n shows digit ((n-1)/SD)%8 from the frame held
    // before that edge; every 8*SD edges the current inputs become the frame.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edges      = 0;
            disp_digit = 0;
            for (int k = 0; k < 8; k++) frame[k] = 4'd0;
            exp_an    = 8'hFF;
            exp_seg_a = 8'hFF;
            exp_seg_b = 8'hFF;
        end else begin
            edges++;
            disp_digit = ((edges - 1) / SD) % 8;
            if (if_a.disp_en) begin
                exp_an    = ~(8'b1 << disp_digit);
                exp_seg_a = ref_seg(disp_digit, 1'b0);
                exp_seg_b = ref_seg(disp_digit, 1'b1);
            end else begin
                exp_an    = 8'hFF;
                exp_seg_a = 8'hFF;
                exp_seg_b = 8'hFF;
            end
            if (edges % (8 * SD) == 0) begin
                frame[0] = if_a.d0; frame[1] = if_a.d1;
                frame[2] = if_a.d2; frame[3] = if_a.d3;
                frame[4] = if_a.d4; frame[5] = if_a.d5;
                frame[6] = if_a.d6; frame[7] = if_a.d7;
            end
        end
    end

    task automatic compare(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("[TB] FAIL %s at edge %0d: observed=%h expected=%h", tag, edges, obs, exp_v);
        end
    endtask

    task automatic check_output();
        compare("an_a",  if_a.an,  exp_an);
        compare("seg_a", if_a.seg, exp_seg_a);
        compare("an_b",  if_b.an,  exp_an);
        compare("seg_b", if_b.seg, exp_seg_b);
    endtask

    task automatic apply_stimulus(input int n);
        repeat (n) begin
            @(negedge clk);
            check_output();
        end
    endtask

    task automatic set_digits(input logic [31:0] v);
        if_a.d0 = v[3:0];   if_b.d0 = v[3:0];
        if_a.d1 = v[7:4];   if_b.d1 = v[7:4];
        if_a.d2 = v[11:8];  if_b.d2 = v[11:8];
        if_a.d3 = v[15:12]; if_b.d3 = v[15:12];
        if_a.d4 = v[19:16]; if_b.d4 = v[19:16];
        if_a.d5 = v[23:20]; if_b.d5 = v[23:20];
        if_a.d6 = v[27:24]; if_b.d6 = v[27:24];
        if_a.d7 = v[31:28]; if_b.d7 = v[31:28];
    endtask

    task automatic set_en(input logic en);
        if_a.disp_en = en;
        if_b.disp_en = en;
    endtask

    task automatic wait_digit(input int target);
        bit found;
        found = 1'b0;
        for (int c = 0; c < 64 && !found; c++) begin
            @(negedge clk);
            check_output();
            if (disp_digit == target) found = 1'b1;
        end
        total++;
        assert (found) else begin
            bad++;
            $error("[TB] FAIL wait_digit: observed=not reached expected=digit %0d", target);
        end
    endtask

    // Directed scenarios followed by randomized digits and enable toggles.
    initial begin
        logic [31:0] v;
        int          lz;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        set_en(1'b1);
        set_digits(32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] reset release: digit 0 shows 0, digit 1 blank on BLANK_LEAD=1");
        set_digits(32'h76543210);
        for (int c = 0; c < SD; c++) begin
            @(negedge clk);
            check_output();
            compare("rst_an_fe",  if_b.an,  8'hFE);
            compare("rst_seg_c0", if_b.seg, 8'hC0);
        end
        @(negedge clk);
        check_output();
        compare("rst_an_fd",  if_b.an,  8'hFD);
        compare("rst_seg_ff", if_b.seg, 8'hFF);

        $display("[TB] scan order 76543210");
        apply_stimulus(16 * SD);

        $display("[TB] mid-scan asynchronous reset");
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        compare("async_an",  if_a.an,  8'hFF);
        compare("async_seg", if_a.seg, 8'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(10 * SD);

        $display("[TB] leading-zero blanking");
        set_digits(32'h00000120);
        apply_stimulus(16 * SD);
        set_digits(32'h00000000);
        apply_stimulus(16 * SD);

        $display("[TB] frame coherence");
        set_digits(32'h00000003);
        apply_stimulus(8 * SD);
        wait_digit(4);
        set_digits(32'h00000008);
        apply_stimulus(12 * SD);

        $display("[TB] invalid code");
        set_digits(32'h10000B00);
        apply_stimulus(16 * SD);

        $display("[TB] disp_en toggle");
        wait_digit(3);
        set_en(1'b0);
        apply_stimulus(10);
        set_en(1'b1);
        apply_stimulus(10 * SD);

        $display("[TB] randomized digits");
        for (int it = 0; it < 25; it++) begin
            v  = $urandom;
            lz = $urandom_range(0, 8);
            if (lz > 0) v = v & (32'hFFFFFFFF >> (4 * lz));
            set_digits(v);
            if ($urandom_range(0, 3) == 0) set_en(1'($urandom_range(0, 1)));
            apply_stimulus($urandom_range(1, 40));
        end
        set_en(1'b1);
        apply_stimulus(16 * SD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
